// File: rtl/fetch_unit.sv
// Instruction-fetch stage: sequential PC generation, single-outstanding imem
// requests, prefetch FIFO toward decode, and redirect-driven wrong-path flush.
module fetch_unit #(
  parameter int unsigned          XLEN     = 32,
  parameter int unsigned          DEPTH    = 2,
  parameter logic [XLEN-1:0]      RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RST,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    RUN,
    WAIT,
    DROP
  } state_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;
  logic            issue;
  logic            push;
  logic            pop;

  // RUN implies nothing outstanding, so the slot test reduces to count < DEPTH.
  always_comb begin
    imem_req    = RST && (state == RUN) && !redirect && (count < (PW+1)'(DEPTH));
    issue       = imem_req && imem_ready;
    push        = (state == WAIT) && imem_rvalid;
    instr_valid = (count != '0);
    pop         = instr_valid && instr_ready;
    imem_addr   = fetch_pc;
    instr       = data_q[rd_ptr];
    instr_pc    = pc_q[rd_ptr];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_q   <= '{default: '0};
      pc_q     <= '{default: '0};
    end else if (redirect) begin
      // An in-flight request becomes wrong-path unless it returns this very cycle.
      fetch_pc <= redirect_pc & ~XLEN'(3);
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      if ((state != RUN) && !imem_rvalid) state <= DROP;
      else                                state <= RUN;
    end else begin
      case (state)
        RUN: begin
          if (issue) begin
            state    <= WAIT;
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + XLEN'(4);
          end
        end
        WAIT:    if (imem_rvalid) state <= RUN;
        DROP:    if (imem_rvalid) state <= RUN;
        default: state <= RUN;
      endcase
      if (push) begin
        data_q[wr_ptr] <= imem_rdata;
        pc_q[wr_ptr]   <= req_pc;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + (PW+1)'(1);
      else if (pop && !push) count <= count - (PW+1)'(1);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural memory responds to issues,
// the expected decode stream is regenerated from the architectural PC on each restart.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'hFFFF_FFF0;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  always #5 CLK = ~CLK;

  fetch_unit #(.XLEN(32), .DEPTH(2), .RESET_PC(RPC)) dut (
    .CLK(CLK), .RST(RST),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic [31:0] iss_log[$];
  int          n_issue = 0;
  int          n_pop = 0;
  int          ready_mode = 1;
  int          fix_delay = 0;
  bit          rand_delay = 0;
  bit          keep_stale = 0;

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural view: decode must see consecutive words from the restart PC.
  task automatic restart(input logic [31:0] pc);
    logic [31:0] p;
    p = pc & ~32'h3;
    exp_q.delete();
    for (int i = 0; i < 512; i++) begin
      exp_q.push_back('{pc: p, ins: word_of(p)});
      p = p + 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    redirect = 1'b0;
    restart(RPC);
    iss_log.delete();
    n_issue = 0;
    tick();
    tick();
    RST = 1'b1;
  endtask

  task automatic wait_issue(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (n_issue < target && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (n_issue < target) begin
      errors++;
      $display("FAIL %s: timeout, issues %0d expected %0d", name, n_issue, target);
    end
  endtask

  // Memory model: one response per issue, delayed by 0..3 extra cycles.
  logic        s_iss;
  logic [31:0] s_addr;
  logic [31:0] m_addr;
  bit          m_out = 0;
  int          m_cnt = 0;

  initial begin
    forever begin
      @(negedge CLK);
      s_iss  = RST && imem_req && imem_ready;
      s_addr = imem_addr;
      if (s_iss) begin
        n_issue++;
        iss_log.push_back(s_addr);
      end
      @(posedge CLK);
      #1;
      imem_rvalid = 1'b0;
      if (!RST && !keep_stale) m_out = 0;
      if (s_iss) begin
        chk("one_outstanding", 32'(m_out), 32'd0);
        m_out  = 1;
        m_addr = s_addr;
        m_cnt  = rand_delay ? int'($urandom_range(0, 3)) : fix_delay;
      end
      if (m_out && RST) begin
        if (m_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = word_of(m_addr);
          m_out       = 0;
        end else begin
          m_cnt--;
        end
      end
      imem_ready = (ready_mode == 1) ? 1'b1 :
                   (ready_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops on every accepted decode handshake plus protocol invariants.
  bit          prev_redir = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_addr = '0;

  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST) begin
        if (prev_redir) chk("flush_empty", 32'(instr_valid), 32'd0);
        if (prev_stall && imem_req) chk("addr_stable", imem_addr, prev_addr);
        if (instr_valid && instr_ready && !redirect) begin
          n_pop++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underrun: pop at pc %h with nothing expected", instr_pc);
          end else begin
            e = exp_q.pop_front();
            chk("sb_pc", instr_pc, e.pc);
            chk("sb_instr", instr, e.ins);
          end
        end
      end
      prev_redir = RST && redirect;
      prev_stall = RST && imem_req && !imem_ready;
      prev_addr  = imem_addr;
    end
  end

  initial begin
    int  p0;
    int  tgt;
    bit  seen;

    restart(RPC);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);

    // Zero-wait streaming, wrap past the top of the address space.
    ready_mode = 1; fix_delay = 0; instr_ready = 1'b1;
    tick();
    RST = 1'b1;
    @(negedge CLK);
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, RPC);
    repeat (4) tick();
    p0 = n_pop;
    repeat (20) tick();
    chk("throughput", 32'(n_pop - p0), 32'd10);
    chk("seq0", iss_log[0], RPC);
    chk("seq1", iss_log[1], RPC + 32'd4);
    chk("seq2", iss_log[2], RPC + 32'd8);
    chk("seq_wrap", iss_log[4], 32'h0);

    // Decode stalled: FIFO fills, fetch stops, then drains in order.
    instr_ready = 1'b0;
    do_reset();
    repeat (12) tick();
    @(negedge CLK);
    chk("full_issues", 32'(n_issue), 32'd2);
    chk("full_req", 32'(imem_req), 32'd0);
    chk("full_valid", 32'(instr_valid), 32'd1);
    chk("full_head", instr_pc, RPC);
    tick();
    instr_ready = 1'b1;
    repeat (8) tick();
    chk("resume_addr", iss_log[2], RPC + 32'd8);

    // Redirect while a request is outstanding; its word must be dropped.
    fix_delay = 2;
    tgt = n_issue + 1;
    wait_issue(tgt, 20, "redir_issue");
    redirect = 1'b1;
    redirect_pc = 32'h103;
    restart(redirect_pc);
    tick();
    redirect = 1'b0;
    @(negedge CLK);
    chk("drop_noreq", 32'(imem_req), 32'd0);
    fix_delay = 0;
    tgt = n_issue + 1;
    wait_issue(tgt, 20, "redir_next");
    chk("redir_addr", iss_log[$], 32'h100);
    repeat (6) tick();

    // Memory not ready: address holds, exactly one issue when ready appears.
    ready_mode = 2;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("stall_req", 32'(imem_req), 32'd1);
      chk("stall_addr", imem_addr, RPC);
      if (i < 2) tick();
    end
    ready_mode = 1;
    tick();
    ready_mode = 2;
    repeat (5) tick();
    chk("single_issue", 32'(n_issue), 32'd1);
    chk("issue_addr", iss_log[0], RPC);

    // Reset while WAIT; the late response must be ignored.
    ready_mode = 1; fix_delay = 3;
    do_reset();
    wait_issue(1, 10, "stale_issue");
    keep_stale = 1;
    ready_mode = 2;
    RST = 1'b0;
    restart(RPC);
    iss_log.delete();
    n_issue = 0;
    tick();
    RST = 1'b1;
    seen = 0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge CLK);
      if (imem_rvalid) seen = 1;
    end
    chk("stale_seen", 32'(seen), 32'd1);
    @(negedge CLK);
    chk("stale_valid", 32'(instr_valid), 32'd0);
    chk("stale_req", 32'(imem_req), 32'd1);
    chk("stale_addr", imem_addr, RPC);
    keep_stale = 0; ready_mode = 1; fix_delay = 0;
    repeat (10) tick();
    chk("post_first", iss_log[0], RPC);

    // Randomised traffic: ready, latency, decode backpressure and redirects.
    ready_mode = 0; rand_delay = 1;
    do_reset();
    p0 = n_pop;
    for (int i = 0; i < 3000; i++) begin
      instr_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 24) == 0) begin
        redirect = 1'b1;
        redirect_pc = $urandom;
        restart(redirect_pc);
      end else begin
        redirect = 1'b0;
      end
      tick();
    end
    redirect = 1'b0;
    instr_ready = 1'b1;
    repeat (10) tick();
    chk("rand_progress", 32'(n_pop - p0 > 300), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
